// File: rtl/dm_pkg.sv
// Shared encodings for the banked data memory: access sizes and controller states.
package dm_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_ILL = 2'b11
  } dm_size_e;

  typedef enum logic [1:0] {
    ST_INIT = 2'b00,
    ST_IDLE = 2'b01,
    ST_WAIT = 2'b10,
    ST_RESP = 2'b11
  } dm_state_e;

endpackage

// File: rtl/dm_lane_fmt.sv
// Byte-lane formatting: store byte enables and lane-replicated data, load extraction
// with sign/zero extension, and the alignment check for half/word accesses.
module dm_lane_fmt
  import dm_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        misalign
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    be         = 4'b0000;
    wdata_lane = 32'h0;
    rdata_ext  = 32'h0;
    misalign   = 1'b0;
    rbyte      = rword[{lane, 3'b000} +: 8];
    rhalf      = rword[{lane[1], 4'b0000} +: 16];
    case (dm_size_e'(size))
      SZ_B: begin
        be         = 4'b0001 << lane;
        // Replicating the data lets the byte enable alone pick the target lane.
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = is_unsigned ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
      end
      SZ_H: begin
        misalign   = lane[0];
        be         = lane[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = is_unsigned ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
      end
      SZ_W: begin
        misalign   = (lane != 2'b00);
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rword;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_banked_wait.sv
// Byte-addressed data memory behind a valid/ready request port with programmable
// wait states, a one-cycle response pulse and optional zero-clear after reset.
module dm_banked_wait
  import dm_pkg::*;
#(
  parameter int DEPTH          = 1024,
  parameter int ADDR_W         = 32,
  parameter int LATENCY        = 1,
  parameter int CLEAR_ON_RESET = 1,
  parameter int DEBUG          = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              init_done
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam dm_state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_IDLE;
  localparam bit unused_debug = (DEBUG != 0);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // resp_valid is a single-cycle pulse with no backpressure.

  dm_state_e         state, state_nxt;
  logic [IDX_W-1:0]  clr_cnt;
  logic [CNT_W-1:0]  wait_cnt;
  logic              we_q, uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       mem [0:DEPTH-1];

  logic              accept, commit, err, misalign, out_of_range;
  logic [IDX_W-1:0]  idx, mem_idx;
  logic [3:0]        be, mem_be;
  logic [31:0]       rword, wdata_lane, rdata_ext, mem_wd;
  logic              mem_we;

  assign req_ready    = (state == ST_IDLE) && init_done;
  assign resp_valid   = (state == ST_RESP);
  assign accept       = req_ready && req_valid;
  assign commit       = (state == ST_WAIT) && (wait_cnt == '0);
  assign idx          = addr_q[IDX_W+1:2];
  assign rword        = mem[idx];
  assign out_of_range = (addr_q >> (IDX_W + 2)) != '0;
  assign err          = misalign || (dm_size_e'(size_q) == SZ_ILL) || out_of_range;

  dm_lane_fmt u_fmt (
    .size        (size_q),
    .lane        (addr_q[1:0]),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .rword       (rword),
    .be          (be),
    .wdata_lane  (wdata_lane),
    .rdata_ext   (rdata_ext),
    .misalign    (misalign)
  );

  // The clear sweep and committed stores share the single array write port.
  always_comb begin
    mem_we  = 1'b0;
    mem_idx = idx;
    mem_be  = be;
    mem_wd  = wdata_lane;
    if (state == ST_INIT) begin
      mem_we  = 1'b1;
      mem_idx = clr_cnt;
      mem_be  = 4'b1111;
      mem_wd  = 32'h0;
    end else if (commit && we_q && !err) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wd[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (clr_cnt == IDX_W'(DEPTH - 1)) state_nxt = ST_IDLE;
      ST_IDLE: if (accept) state_nxt = ST_WAIT;
      ST_WAIT: if (wait_cnt == '0) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RST_STATE;
      clr_cnt    <= '0;
      wait_cnt   <= '0;
      init_done  <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
    end else begin
      state <= state_nxt;
      if (state_nxt != ST_INIT) init_done <= 1'b1;
      if (state == ST_INIT) clr_cnt <= clr_cnt + 1'b1;
      if (accept) begin
        we_q     <= req_we;
        uns_q    <= req_unsigned;
        size_q   <= req_size;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        wait_cnt <= CNT_LOAD;
      end else if ((state == ST_WAIT) && (wait_cnt != '0)) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
      if (commit) begin
        resp_err   <= err;
        resp_rdata <= (err || we_q) ? 32'h0 : rdata_ext;
      end
    end
  end

endmodule

// File: tb/tb_dm_banked_wait.sv
// Bench for dm_banked_wait: directed scenarios plus random traffic against a
// byte-array reference model.
module tb_dm_banked_wait;

  localparam int DEPTH   = 16;
  localparam int LATENCY = 3;
  localparam int NBYTES  = DEPTH * 4;
  localparam int BOUND   = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        init_done;

  int checks = 0;
  int failures = 0;
  logic [7:0]  mdl_mem [0:NBYTES-1];
  logic [32:0] exp_q[$];

  dm_banked_wait #(
    .DEPTH(DEPTH), .ADDR_W(32), .LATENCY(LATENCY), .CLEAR_ON_RESET(1), .DEBUG(0)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .init_done(init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit mdl_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) ||
           (sz == 2'd2 && (a % 4) != 0) || (a >= NBYTES);
  endfunction

  function automatic logic [31:0] mdl_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
    int nb;
    longint v;
    nb = 1 << sz;
    v = 0;
    for (int i = 0; i < nb; i++) v += longint'(mdl_mem[a + i]) << (8 * i);
    if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= longint'(1) << (8 * nb);
    return v[31:0];
  endfunction

  task automatic mdl_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int nb;
    nb = 1 << sz;
    for (int i = 0; i < nb; i++) mdl_mem[a + i] = 8'(wd >> (8 * i));
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < NBYTES; i++) mdl_mem[i] = 8'h00;
  endtask

  // Called at a negedge while idle; returns at a negedge with the block idle again.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got);
    int n;
    int lat;
    logic e;
    logic [31:0] exp;
    logic [32:0] ent;
    got = 32'h0;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd;
    n = 0;
    while (req_ready !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
    if (n >= BOUND) begin
      check("ready_timeout", 32'(req_ready), 32'h1);
      req_valid = 1'b0;
      return;
    end
    e = mdl_err(sz, a);
    exp = (e || we) ? 32'h0 : mdl_load(sz, uns, a);
    if (!e && we) mdl_store(sz, a, wd);
    exp_q.push_back({e, exp});
    @(negedge clk);
    // Inputs are scrambled once the request is taken; the block must ignore them.
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 0;
    while (resp_valid !== 1'b1 && lat < BOUND) begin
      check("busy_ready", 32'(req_ready), 32'h0);
      @(negedge clk);
      lat++;
    end
    ent = exp_q.pop_front();
    if (resp_valid !== 1'b1) begin
      check("resp_timeout", 32'(resp_valid), 32'h1);
      return;
    end
    check("latency", 32'(lat), 32'(LATENCY));
    check("resp_ready", 32'(req_ready), 32'h0);
    check("rdata", resp_rdata, ent[31:0]);
    check("err", 32'(resp_err), 32'(ent[32]));
    got = resp_rdata;
    @(negedge clk);
    check("pulse_end", 32'(resp_valid), 32'h0);
    check("ready_back", 32'(req_ready), 32'h1);
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (init_done !== 1'b1 && n < BOUND) begin @(negedge clk); n++; end
    check(tag, 32'(n), 32'(DEPTH));
  endtask

  initial begin
    logic [31:0] got;
    logic [1:0]  sz;
    logic [31:0] a;

    // Reset values while rst is held.
    mdl_clear();
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_valid", 32'(resp_valid), 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", 32'(resp_err), 32'h0);
    check("rst_init_done", 32'(init_done), 32'h0);
    rst = 1'b0;
    wait_init("init_cycles");

    // Cleared array reads back zero.
    for (int w = 0; w < DEPTH; w++) begin
      do_req(1'b0, 2'd2, 1'b0, 32'(4 * w), 32'h0, got);
      check("clr_word", got, 32'h0);
    end

    // Extension on byte/half loads.
    do_req(1'b1, 2'd2, 1'b0, 32'h4, 32'h8000F0FF, got);
    do_req(1'b0, 2'd0, 1'b0, 32'h4, 32'h0, got); check("lb", got, 32'hFFFFFFFF);
    do_req(1'b0, 2'd0, 1'b1, 32'h4, 32'h0, got); check("lbu", got, 32'h000000FF);
    do_req(1'b0, 2'd1, 1'b0, 32'h6, 32'h0, got); check("lh", got, 32'hFFFF8000);
    do_req(1'b0, 2'd1, 1'b1, 32'h6, 32'h0, got); check("lhu", got, 32'h00008000);

    // Partial stores merge into an existing word.
    do_req(1'b1, 2'd2, 1'b0, 32'h8, 32'h11223344, got);
    do_req(1'b1, 2'd0, 1'b0, 32'h9, 32'h000000AA, got);
    do_req(1'b1, 2'd1, 1'b0, 32'hA, 32'h0000BEEF, got);
    do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, got); check("merge", got, 32'hBEEFAA44);

    // Error cases: nothing is written and load data is zero.
    do_req(1'b1, 2'd1, 1'b0, 32'h3, 32'h0000DEAD, got); check("err_sh", got, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h2, 32'h0, got);        check("err_lw", got, 32'h0);
    do_req(1'b1, 2'd2, 1'b0, 32'h2, 32'hCAFEF00D, got);
    do_req(1'b1, 2'd3, 1'b0, 32'h0, 32'h55555555, got);
    do_req(1'b0, 2'd3, 1'b0, 32'h4, 32'h0, got);        check("err_size", got, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'(NBYTES), 32'h0, got);  check("err_range", got, 32'h0);
    do_req(1'b1, 2'd2, 1'b0, 32'(NBYTES), 32'h77777777, got);
    do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, got); check("keep_w0", got, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, got); check("keep_w1", got, 32'h8000F0FF);

    // Random traffic against the model.
    for (int t = 0; t < 250; t++) begin
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a = ($urandom_range(0, 9) == 0) ? ($urandom | 32'(NBYTES)) : 32'($urandom_range(0, NBYTES - 1));
      if ($urandom_range(0, 4) != 0 && sz != 2'd3) a = a & ~((32'h1 << sz) - 32'h1);
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom, got);
    end

    // Reset while a store is waiting: no response, store never lands, clear restarts.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h12345678;
    check("pre_rst_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_resp", 32'(resp_valid), 32'h0);
      check("rst_done_low", 32'(init_done), 32'h0);
    end
    rst = 1'b0;
    mdl_clear();
    wait_init("reinit_cycles");
    do_req(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, got); check("after_rst_w0", got, 32'h0);
    do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0, got); check("after_rst_w2", got, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
